// File: rtl/uk101_kbd_pkg.sv
// Shared constants and types for the UK101 PS/2 keyboard front end.
package uk101_kbd_pkg;

  // Scancode-set-2 prefix and overrun bytes
  localparam logic [7:0] SC_RELEASE  = 8'hF0;
  localparam logic [7:0] SC_EXTEND   = 8'hE0;
  localparam logic [7:0] SC_PAUSE    = 8'hE1;
  localparam logic [7:0] SC_OVERRUN0 = 8'h00;
  localparam logic [7:0] SC_OVERRUN1 = 8'hFF;

  // Bytes that follow E1 in the Pause make sequence and carry no key of their own
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_frame_state_t;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter for one PS/2 line.
// The filtered output idles high and only moves after FILTER_LEN consecutive
// synchronised samples disagree with it.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic n_reset,
  input  logic line_raw,
  output logic line_filt
);

  logic       sync_q1;
  logic       sync_q2;
  logic [7:0] run_cnt;

  // Bring the asynchronous line into the clk domain; idle level is high
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= line_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the run
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      line_filt <= 1'b1;
      run_cnt   <= 8'd0;
    end else if (sync_q2 != line_filt) begin
      if (run_cnt == 8'(FILTER_LEN - 1)) begin
        line_filt <= sync_q2;
        run_cnt   <= 8'd0;
      end else begin
        run_cnt <= run_cnt + 8'd1;
      end
    end else begin
      run_cnt <= 8'd0;
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: line conditioning, 11-bit frame deserialiser and
// scancode-set-2 prefix resolution, producing one registered event per key.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for a start bit (falling edge with data low)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking stop bit and parity, then byte-layer decode
import uk101_kbd_pkg::*;

module ps2_kbd_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int                TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic             clk_f;
  logic             data_f;
  logic             clk_f_d;
  logic             fall;

  ps2_frame_state_t state;
  logic [7:0]       shreg;
  logic [2:0]       bit_cnt;
  logic             par_bit;
  logic [TO_W-1:0]  to_cnt;
  logic             ext_pend;
  logic             rel_pend;
  logic [2:0]       skip_cnt;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_clk (
    .clk       (clk),
    .n_reset   (n_reset),
    .line_raw  (ps2Clk),
    .line_filt (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_data (
    .clk       (clk),
    .n_reset   (n_reset),
    .line_raw  (ps2Data),
    .line_filt (data_f)
  );

  // Delay the filtered clock one cycle so a high-to-low change can be seen
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      clk_f_d <= 1'b1;
    end else begin
      clk_f_d <= clk_f;
    end
  end

  assign fall = clk_f_d & ~clk_f;

  // Frame FSM, timeout and byte layer; all outputs are registered here
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      shreg        <= 8'd0;
      bit_cnt      <= 3'd0;
      par_bit      <= 1'b0;
      to_cnt       <= '0;
      ext_pend     <= 1'b0;
      rel_pend     <= 1'b0;
      skip_cnt     <= 3'd0;
      key_valid    <= 1'b0;
      key_code     <= 8'd0;
      key_extended <= 1'b0;
      key_release  <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      key_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      unique case (state)
        IDLE: begin
          to_cnt <= '0;
          if (fall) begin
            if (!data_f) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end else begin
              frame_err <= 1'b1;
              ext_pend  <= 1'b0;
              rel_pend  <= 1'b0;
              skip_cnt  <= 3'd0;
            end
          end
        end

        DATA, PARITY, STOP: begin
          if (fall) begin
            to_cnt <= '0;
            if (state == DATA) begin
              shreg   <= {data_f, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= PARITY;
              end
            end else if (state == PARITY) begin
              par_bit <= data_f;
              state   <= STOP;
            end else begin
              state <= IDLE;
              if (!data_f) begin
                // A bad stop bit outranks a parity failure
                frame_err <= 1'b1;
                ext_pend  <= 1'b0;
                rel_pend  <= 1'b0;
                skip_cnt  <= 3'd0;
              end else if (!odd_parity_ok(shreg, par_bit)) begin
                parity_err <= 1'b1;
                ext_pend   <= 1'b0;
                rel_pend   <= 1'b0;
                skip_cnt   <= 3'd0;
              end else if (skip_cnt != 3'd0) begin
                // Pause tail bytes are swallowed whatever their value
                skip_cnt <= skip_cnt - 3'd1;
              end else if (shreg == SC_RELEASE) begin
                rel_pend <= 1'b1;
              end else if (shreg == SC_EXTEND) begin
                ext_pend <= 1'b1;
              end else if (shreg == SC_PAUSE) begin
                skip_cnt <= PAUSE_TAIL;
              end else if (shreg == SC_OVERRUN0 || shreg == SC_OVERRUN1) begin
                ext_pend <= 1'b0;
                rel_pend <= 1'b0;
              end else begin
                key_valid    <= 1'b1;
                key_code     <= shreg;
                key_extended <= ext_pend;
                key_release  <= rel_pend;
                ext_pend     <= 1'b0;
                rel_pend     <= 1'b0;
              end
            end
          end else if (to_cnt == TO_LAST) begin
            // Keyboard stopped clocking mid-frame: drop it and any pending prefix
            state     <= IDLE;
            to_cnt    <= '0;
            frame_err <= 1'b1;
            ext_pend  <= 1'b0;
            rel_pend  <= 1'b0;
            skip_cnt  <= 3'd0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed frame table, hand-written
// timeout and reset sequences, then random frames against a prefix model.
module tb_ps2_kbd_rx;

  localparam int FL  = 8;
  localparam int TC  = 300;
  localparam int H   = 30;       // PS/2 clock half period in clk cycles
  localparam int LAT = FL + 3;   // drive of a falling edge -> strobe visible

  logic       clk = 1'b0;
  logic       n_reset;
  logic       ps2Clk;
  logic       ps2Data;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_release;
  logic       parity_err;
  logic       frame_err;

  always #10 clk = ~clk;

  ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TC)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .ps2Clk       (ps2Clk),
    .ps2Data      (ps2Data),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_extended (key_extended),
    .key_release  (key_release),
    .parity_err   (parity_err),
    .frame_err    (frame_err)
  );

  typedef struct {
    logic [7:0] b;
    bit         flip;
    bit         stopv;
    bit         glitch;
    int         exp_nv;
    logic [7:0] code;
    bit         ext;
    bit         rel;
    int         exp_np;
    int         exp_nf;
  } vec_t;

  vec_t tv[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int nv, np, nf, kv_cyc, ferr_cyc, edge_cyc;
  logic [7:0] got_code;
  logic got_ext, got_rel;

  // reference model state: pending prefixes and pause bytes still to swallow
  bit m_ext, m_rel;
  int m_skip;

  function automatic vec_t mk(input logic [7:0] b, input bit flip, input bit stopv,
                              input bit glitch, input int env, input logic [7:0] code,
                              input bit ext, input bit rel, input int enp, input int enf);
    vec_t v;
    v.b = b; v.flip = flip; v.stopv = stopv; v.glitch = glitch;
    v.exp_nv = env; v.code = code; v.ext = ext; v.rel = rel;
    v.exp_np = enp; v.exp_nf = enf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_cnt++;
    if (key_valid === 1'b1) begin
      nv++;
      got_code = key_code;
      got_ext  = key_extended;
      got_rel  = key_release;
      kv_cyc   = cyc_cnt;
    end
    if (parity_err === 1'b1) np++;
    if (frame_err === 1'b1) begin
      if (nf == 0) ferr_cyc = cyc_cnt;
      nf++;
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) cyc();
  endtask

  task automatic clear_stats();
    nv = 0; np = 0; nf = 0; kv_cyc = -1000; ferr_cyc = -1000;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2Data = b;
    if (glitch) begin
      wait_n(H / 2);
      ps2Clk = 1'b0;
      wait_n(3);
      ps2Clk = 1'b1;
      wait_n(H - H / 2 - 3);
    end else begin
      wait_n(H);
    end
    ps2Clk   = 1'b0;
    edge_cyc = cyc_cnt;
    wait_n(H);
    ps2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip, input bit stopv, input bit glitch);
    logic [10:0] bits;
    logic        p;
    p    = ~(^b) ^ flip;
    bits = {stopv, p, b, 1'b0};
    clear_stats();
    for (int i = 0; i < 11; i++) send_bit(bits[i], glitch);
    ps2Data = 1'b1;
    wait_n(2 * H);
  endtask

  task automatic check_frame(input string tag, input int env, input logic [7:0] code,
                             input bit ext, input bit rel, input int enp, input int enf);
    chk({tag, " key_valid count"}, nv, env);
    chk({tag, " parity_err count"}, np, enp);
    chk({tag, " frame_err count"}, nf, enf);
    if (env == 1) begin
      chk({tag, " key_code"}, got_code, code);
      chk({tag, " key_extended"}, got_ext, ext);
      chk({tag, " key_release"}, got_rel, rel);
      chk({tag, " latency"}, kv_cyc - edge_cyc, LAT);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit flip, input bit stopv,
                             output int env, output logic [7:0] ec, output bit ee,
                             output bit er, output int enp, output int enf);
    env = 0; ec = 8'd0; ee = 1'b0; er = 1'b0; enp = 0; enf = 0;
    if (!stopv) begin
      enf = 1; m_ext = 0; m_rel = 0; m_skip = 0;
    end else if (flip) begin
      enp = 1; m_ext = 0; m_rel = 0; m_skip = 0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else begin
      case (b)
        8'hF0:        m_rel = 1;
        8'hE0:        m_ext = 1;
        8'hE1:        m_skip = 7;
        8'h00, 8'hFF: begin m_ext = 0; m_rel = 0; end
        default: begin
          env = 1; ec = b; ee = m_ext; er = m_rel;
          m_ext = 0; m_rel = 0;
        end
      endcase
    end
  endtask

  initial begin
    int         env, enp, enf;
    logic [7:0] ec, rb;
    bit         ee, er, rflip, rstop, rgl;
    int         sel;

    // byte, flip, stop, glitch | nv, code, ext, rel, np, nf
    tv.push_back(mk(8'h1C, 0, 1, 0, 1, 8'h1C, 0, 0, 0, 0));
    tv.push_back(mk(8'hF0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'h1C, 0, 1, 0, 1, 8'h1C, 0, 1, 0, 0));
    tv.push_back(mk(8'hE0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'hF0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'h75, 0, 1, 0, 1, 8'h75, 1, 1, 0, 0));
    tv.push_back(mk(8'hE0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'h1C, 1, 1, 0, 0, 8'h00, 0, 0, 1, 0));
    tv.push_back(mk(8'h32, 0, 1, 0, 1, 8'h32, 0, 0, 0, 0));
    tv.push_back(mk(8'hF0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'h1C, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1));
    tv.push_back(mk(8'h29, 0, 1, 0, 1, 8'h29, 0, 0, 0, 0));
    tv.push_back(mk(8'h5A, 1, 0, 0, 0, 8'h00, 0, 0, 0, 1));
    tv.push_back(mk(8'h1C, 0, 1, 1, 1, 8'h1C, 0, 0, 0, 0));
    tv.push_back(mk(8'hE1, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'h14, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'h77, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'hE1, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'hF0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'h14, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'hF0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'h77, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'h1C, 0, 1, 0, 1, 8'h1C, 0, 0, 0, 0));
    tv.push_back(mk(8'hE0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'h5A, 0, 1, 0, 1, 8'h5A, 0, 0, 0, 0));
    tv.push_back(mk(8'hF0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'hFF, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
    tv.push_back(mk(8'h66, 0, 1, 0, 1, 8'h66, 0, 0, 0, 0));

    n_reset = 1'b0;
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    clear_stats();
    wait_n(5);
    chk("reset outputs", {key_valid, key_code, key_extended, key_release, parity_err, frame_err}, 0);
    n_reset = 1'b1;
    wait_n(FL + 5);

    for (int i = 0; i < tv.size(); i++) begin
      send_frame(tv[i].b, tv[i].flip, tv[i].stopv, tv[i].glitch);
      check_frame($sformatf("vec%0d", i), tv[i].exp_nv, tv[i].code, tv[i].ext,
                  tv[i].rel, tv[i].exp_np, tv[i].exp_nf);
    end

    // Partial frame after an E0: 5 falling edges then the clock stalls low
    send_frame(8'hE0, 0, 1, 0);
    check_frame("pre-timeout E0", 0, 8'h00, 0, 0, 0, 0);
    clear_stats();
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    ps2Data = 1'b1;
    wait_n(H);
    ps2Clk   = 1'b0;
    edge_cyc = cyc_cnt;
    for (int k = 0; k < LAT + TC + 50 && nf == 0; k++) cyc();
    chk("timeout frame_err", nf, 1);
    chk("timeout delay", ferr_cyc - edge_cyc, LAT + TC);
    chk("timeout key_valid", nv, 0);
    ps2Clk = 1'b1;
    wait_n(H);
    send_frame(8'h29, 0, 1, 0);
    check_frame("post-timeout 29", 1, 8'h29, 0, 0, 0, 0);

    // Reset asserted in the middle of a frame
    clear_stats();
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    ps2Clk = 1'b0;
    wait_n(FL + 5);
    n_reset = 1'b0;
    #1;
    chk("mid-frame reset outputs",
        {key_valid, key_code, key_extended, key_release, parity_err, frame_err}, 0);
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    wait_n(4);
    n_reset = 1'b1;
    wait_n(FL + 5);
    send_frame(8'h1C, 0, 1, 0);
    check_frame("post-reset 1C", 1, 8'h1C, 0, 0, 0, 0);

    // Random frames against the prefix model (all prefixes are clear here)
    m_ext = 0; m_rel = 0; m_skip = 0;
    for (int i = 0; i < 25; i++) begin
      sel = $urandom_range(0, 15);
      case (sel)
        0, 1:    rb = 8'hF0;
        2, 3:    rb = 8'hE0;
        4:       rb = 8'hE1;
        5:       rb = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      rflip = ($urandom_range(0, 9) == 0);
      rstop = ($urandom_range(0, 11) != 0);
      rgl   = ($urandom_range(0, 3) == 0);
      model_frame(rb, rflip, rstop, env, ec, ee, er, enp, enf);
      send_frame(rb, rflip, rstop, rgl);
      check_frame($sformatf("rnd%0d b=%02h", i, rb), env, ec, ee, er, enp, enf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver and scancode-set-2 framer. It sits between the HPS PS/2 keyboard outputs and the UK101 keyboard-matrix logic inside uk101. It filters and synchronises the PS/2 clock and data lines, deserialises 11-bit frames, checks parity and framing, and resolves the E0/F0/E1 prefixes. Each completed key is emitted as one registered event: code, extended flag and release flag, qualified by a single-cycle strobe.

Parameters:
FILTER_LEN, 8, number of consecutive identical synchronised samples required before a filtered line changes level (valid range 2..255).
TIMEOUT_CYCLES, 100000, clk cycles without a filtered ps2Clk falling edge before a partial frame is abandoned (2 ms at 50 MHz).

Ports:
clk  in  1  system clock, 50 MHz.
n_reset  in  1  asynchronous active-low reset.
ps2Clk  in  1  raw PS/2 clock from hps_io; asynchronous to clk.
ps2Data  in  1  raw PS/2 data from hps_io; asynchronous to clk.
key_valid  out  1  one-cycle strobe; a key event is present.
key_code  out  8  scancode, valid when key_valid is high; held until the next event.
key_extended  out  1  event was E0-prefixed; held with key_code.
key_release  out  1  event was F0-prefixed (break code); held with key_code.
parity_err  out  1  one-cycle strobe; a frame failed the odd-parity check.
frame_err  out  1  one-cycle strobe; bad start bit, bad stop bit, or timeout.

Behaviour:
- Reset: all outputs are 0. FSM is IDLE. Shift register, bit count, timeout counter and prefix flags are cleared. Filtered lines are set to 1. Reset asserted mid-frame discards the frame immediately with no strobes.
- Input conditioning: each line passes through a 2-flop synchroniser, then a counter filter. The filtered output toggles only after FILTER_LEN consecutive samples that differ from the current filtered value. Pulses shorter than FILTER_LEN cycles are ignored.
- Falling-edge detect: a registered compare of the filtered ps2Clk. A bit is sampled from the filtered ps2Data on the detect cycle.
- Frame FSM:
  - IDLE: on a falling edge, data 0 -> DATA with bit count 0. Data 1 -> pulse frame_err and stay in IDLE.
  - DATA: shifts 8 bits LSB-first; after the 8th bit -> PARITY.
  - PARITY: captures the parity bit -> STOP.
  - STOP: stop bit 1 with odd parity over data+parity -> byte_done. Stop bit 0 -> frame_err. Parity bad with stop good -> parity_err. Both bad -> frame_err only. Always returns to IDLE.
- Timeout: the counter runs only in non-IDLE states and is reset on every falling edge. On reaching TIMEOUT_CYCLES: pulse frame_err, return to IDLE, clear the prefix flags.
- Byte layer, on byte_done:
  - F0 sets rel_pend.
  - E0 sets ext_pend.
  - E1 loads skip_cnt=7.
  - While skip_cnt>0, each byte decrements it and nothing is emitted.
  - 00 and FF (keyboard overrun) clear the flags and emit nothing.
  - Any other byte emits an event: key_code=byte, key_extended=ext_pend, key_release=rel_pend; then both flags clear.
- Error handling: a parity_err or frame_err clears ext_pend, rel_pend and skip_cnt.
- Latency: key_valid rises on the cycle after the stop-bit falling edge is detected. Outputs are registered.
- Throughput: at most one event per frame; back-to-back frames have no dead time.

Decomposition:
- Package uk101_kbd_pkg:
  - SC_RELEASE=8'hF0, SC_EXTEND=8'hE0, SC_PAUSE=8'hE1, SC_OVERRUN0=8'h00, SC_OVERRUN1=8'hFF, PAUSE_TAIL=3'd7.
  - typedef enum ps2_frame_state_t {IDLE, DATA, PARITY, STOP}.
- Sub-module ps2_line_filter (synchroniser plus counter filter, parameter FILTER_LEN), instantiated twice: once for clock, once for data.

Test Plan:
1. Valid frame 0x1C at 12.5 kHz PS/2 clock -> exactly one key_valid cycle; code 1C, extended 0, release 0; no error strobes.
2. Frames F0,1C then E0,F0,75 -> two events: (1C,ext 0,rel 1) then (75,ext 1,rel 1); F0 and E0 themselves produce no strobes.
3. 0x1C with a flipped parity bit -> one parity_err pulse, no key_valid. A following E0 flag is not carried: next frame 0x32 yields (32,0,0).
4. Frame with stop bit 0 -> frame_err pulse, no key_valid. Then 5 bits followed by idle -> frame_err exactly TIMEOUT_CYCLES after the 5th edge. A subsequent valid 0x29 decodes as (29,0,0).
5. 3-cycle low glitches on ps2Clk between real edges, with FILTER_LEN=8 -> no extra bits shifted; 0x1C decodes correctly.
6. Pause sequence E1,14,77,E1,F0,14,F0,77 -> zero key_valid. The next 0x1C gives (1C,0,0). Asserting n_reset mid-frame -> all outputs 0 immediately and the next full frame decodes.
